fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Consumer end of the PC/PC+4 path. Holds the architectural fetch PC and issues
//  in-order read requests to instruction memory (valid/ready). It buffers returned
//  words with their PC in a DEPTH-entry queue and presents them to decode (valid/ready).
//  A redirect (branch/jump) reloads the PC, flushes the queue and discards in-flight responses.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  DEPTH     4              queue entries = max requests in flight + buffered (power of 2, >=2)
// PORTS
//  clock           in   1   rising-edge clock
//  reset_n         in   1   async active-low reset
//  redirect_valid  in   1   load redirect_pc, flush queue and in-flight responses
//  redirect_pc     in   32  new fetch PC (word aligned)
//  imem_req_valid  out  1   request pending on imem_req_addr
//  imem_req_addr   out  32  fetch address (= current PC)
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_resp_valid in   1   response word valid (in order, latency >=1 cycle)
//  imem_resp_data  in   32  instruction word
//  instr_valid     out  1   queue head is filled
//  instr_data      out  32  head instruction word
//  instr_pc        out  32  PC of head instruction
//  instr_ready     in   1   decode consumes head this cycle
// BEHAVIOUR
//  - Reset (async, reset_n=0): pc=RESET_PC; alloc/fill/read ptrs=0; drop_cnt=0;
//    imem_req_valid=0 and instr_valid=0 while reset_n=0.
//  - Occupancy occ = entries allocated but not popped + drop_cnt; occ never exceeds DEPTH.
//  - imem_req_valid = reset_n & !redirect_valid & (occ < DEPTH); imem_req_addr = pc.
//  - Request fire (req_valid & req_ready): allocate entry at alloc ptr, store pc, mark unfilled;
//    pc <= pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
//  - Response: if drop_cnt>0, discard word and drop_cnt-1; else write data into entry at
//    fill ptr, mark filled, fill ptr+1. Response with nothing outstanding: ignored.
//  - instr_valid = reset_n & !redirect_valid & head filled; instr_data/instr_pc from head.
//    Pop on instr_valid & instr_ready; read ptr+1, frees one slot the next cycle.
//  - Request, response and pop may all occur in the same cycle; each is applied independently.
//  - Fetch-to-decode latency: response in cycle N -> instr_valid in cycle N+1 (registered).
//  - Redirect (priority over all else, one cycle):
//    pc <= redirect_pc; all queue entries invalidated; ptrs reset to 0;
//    drop_cnt <= drop_cnt + allocated-unfilled count - (1 if a response arrives this cycle);
//    no request fire and no pop in that cycle.
//    The first request at redirect_pc is issued in the next cycle, provided occ < DEPTH.
//  - Back-to-back redirects: the last one wins; drop accounting accumulates.
//  - Pointers are log2(DEPTH)+1 bits; full/empty are distinguished by the MSB.
//  - reset_n asserted mid-operation: everything returns to reset values immediately.
//    Memory-side in-flight responses after reset are not tracked; the system resets imem too.
// TESTING
//  1. Reset, RESET_PC=0, req_ready=1, 1-cycle memory latency -> requests 0,4,8,...;
//     instr_pc/instr_data pairs in order, one per cycle after the first.
//  2. instr_ready=0, memory always ready, DEPTH=4 -> exactly 4 requests (0..C);
//     req_valid stays 0 until one pop, then one request at 0x10.
//  3. Two requests outstanding (latency 3), redirect_pc=0x100 -> both responses dropped;
//     next delivered instr_pc=0x100 with matching data.
//  4. Response and redirect in the same cycle, one more outstanding -> drop_cnt=1;
//     no stale word ever reaches decode.
//  5. redirect_pc=32'hFFFF_FFFC -> requests FFFF_FFFC, then 0000_0000 (wrap).
//  6. reset_n pulsed low mid-stream with a full queue -> outputs 0 immediately;
//     after release, first request addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - in-order instruction fetch with response queue and redirect flush
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

  logic [31:0]    pc_q, pc_d;
  logic [PW-1:0]  alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]  fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]  read_ptr_q, read_ptr_d;
  logic [PW-1:0]  drop_cnt_q, drop_cnt_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [31:0]    entry_pc_q [DEPTH];
  logic [31:0]    entry_pc_d [DEPTH];
  logic [31:0]    entry_data_q [DEPTH];
  logic [31:0]    entry_data_d [DEPTH];

  logic [PW:0]    occ;
  logic [PW-1:0]  in_flight;
  logic [AW-1:0]  alloc_idx, fill_idx, head_idx;
  logic           outstanding, resp_take, req_fire, pop;

  assign alloc_idx = alloc_ptr_q[AW-1:0];
  assign fill_idx  = fill_ptr_q[AW-1:0];
  assign head_idx  = read_ptr_q[AW-1:0];

  // Slots in use include words still owed by memory for flushed requests
  assign in_flight   = alloc_ptr_q - fill_ptr_q;
  assign occ         = {1'b0, alloc_ptr_q - read_ptr_q} + {1'b0, drop_cnt_q};
  assign outstanding = (drop_cnt_q != '0) || (in_flight != '0);
  assign resp_take   = imem_resp_valid && outstanding;

  assign imem_req_valid = reset_n && !redirect_valid && (occ < DEPTH_W);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr_valid = reset_n && !redirect_valid && filled_q[head_idx];
  assign instr_data  = entry_data_q[head_idx];
  assign instr_pc    = entry_pc_q[head_idx];
  assign pop         = instr_valid && instr_ready;

  // Next-state: redirect flushes everything, otherwise request/response/pop apply independently
  always_comb begin
    pc_d         = pc_q;
    alloc_ptr_d  = alloc_ptr_q;
    fill_ptr_d   = fill_ptr_q;
    read_ptr_d   = read_ptr_q;
    drop_cnt_d   = drop_cnt_q;
    filled_d     = filled_q;
    entry_pc_d   = entry_pc_q;
    entry_data_d = entry_data_q;
    if (redirect_valid) begin
      pc_d        = redirect_pc;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      read_ptr_d  = '0;
      filled_d    = '0;
      // A response landing now is one of the owed words, so it needs no later drop
      drop_cnt_d  = drop_cnt_q + in_flight - {{(PW-1){1'b0}}, resp_take};
    end else begin
      if (req_fire) begin
        entry_pc_d[alloc_idx] = pc_q;
        filled_d[alloc_idx]   = 1'b0;
        alloc_ptr_d           = alloc_ptr_q + 1'b1;
        pc_d                  = pc_q + 32'd4;
      end
      if (resp_take) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - 1'b1;
        end else begin
          entry_data_d[fill_idx] = imem_resp_data;
          filled_d[fill_idx]     = 1'b1;
          fill_ptr_d             = fill_ptr_q + 1'b1;
        end
      end
      if (pop) begin
        filled_d[head_idx] = 1'b0;
        read_ptr_d         = read_ptr_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      read_ptr_q  <= '0;
      drop_cnt_q  <= '0;
      filled_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_pc_q[i]   <= '0;
        entry_data_q[i] <= '0;
      end
    end else begin
      pc_q         <= pc_d;
      alloc_ptr_q  <= alloc_ptr_d;
      fill_ptr_q   <= fill_ptr_d;
      read_ptr_q   <= read_ptr_d;
      drop_cnt_q   <= drop_cnt_d;
      filled_q     <= filled_d;
      entry_pc_q   <= entry_pc_d;
      entry_data_q <= entry_data_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table-driven bench for fetch_unit
module tb_fetch_unit;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready)
  );

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rr;
    logic        sv;
    logic [31:0] sd;
    logic        ir;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] dw(input logic [31:0] a);
    return 32'h1000_0000 | a;
  endfunction

  task automatic add(input logic rst, input logic redir, input logic [31:0] rpc,
                     input logic rr, input logic sv, input logic [31:0] sd, input logic ir,
                     input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                     input logic [31:0] e_pc, input logic [31:0] e_data);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.rr = rr; v.sv = sv; v.sd = sd; v.ir = ir;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc; v.e_data = e_data;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then settle before sampling
  task automatic cyc(input logic rst, input logic redir, input logic [31:0] rpc,
                     input logic rr, input logic sv, input logic [31:0] sd, input logic ir);
    @(negedge clock);
    reset_n         = rst;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    imem_req_ready  = rr;
    imem_resp_valid = sv;
    imem_resp_data  = sd;
    instr_ready     = ir;
    #1;
  endtask

  task automatic chk_out(input string name, input logic e_rv, input logic [31:0] e_addr,
                         input logic e_iv, input logic [31:0] e_pc, input logic [31:0] e_data);
    chk({name, " req_valid"}, {31'd0, imem_req_valid}, {31'd0, e_rv});
    chk({name, " req_addr"}, imem_req_addr, e_addr);
    chk({name, " instr_valid"}, {31'd0, instr_valid}, {31'd0, e_iv});
    if (e_iv) begin
      chk({name, " instr_pc"}, instr_pc, e_pc);
      chk({name, " instr_data"}, instr_data, e_data);
    end
  endtask

  initial begin
    reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; instr_ready = 1'b0;

    // Streaming with 1-cycle memory latency, decode always ready
    add(0,0,0, 1,0,0,        1, 0,32'h00, 0,0,0);
    add(1,0,0, 1,0,0,        1, 1,32'h00, 0,0,0);
    add(1,0,0, 1,1,dw(32'h0),1, 1,32'h04, 0,0,0);
    add(1,0,0, 1,1,dw(32'h4),1, 1,32'h08, 1,32'h0,dw(32'h0));
    add(1,0,0, 1,1,dw(32'h8),1, 1,32'h0C, 1,32'h4,dw(32'h4));
    add(1,0,0, 1,1,dw(32'hC),1, 1,32'h10, 1,32'h8,dw(32'h8));
    add(1,0,0, 1,1,dw(32'h10),1,1,32'h14, 1,32'hC,dw(32'hC));
    // Decode stalled: exactly DEPTH requests, one more only after a pop
    add(0,0,0, 1,0,0,        0, 0,32'h00, 0,0,0);
    add(1,0,0, 1,0,0,        0, 1,32'h00, 0,0,0);
    add(1,0,0, 1,1,dw(32'h0),0, 1,32'h04, 0,0,0);
    add(1,0,0, 1,1,dw(32'h4),0, 1,32'h08, 1,32'h0,dw(32'h0));
    add(1,0,0, 1,1,dw(32'h8),0, 1,32'h0C, 1,32'h0,dw(32'h0));
    add(1,0,0, 1,1,dw(32'hC),0, 0,32'h10, 1,32'h0,dw(32'h0));
    add(1,0,0, 1,0,0,        1, 0,32'h10, 1,32'h0,dw(32'h0));
    add(1,0,0, 1,0,0,        0, 1,32'h10, 1,32'h4,dw(32'h4));
    add(1,0,0, 1,1,dw(32'h10),0,0,32'h14, 1,32'h4,dw(32'h4));
    add(1,0,0, 1,0,0,        0, 0,32'h14, 1,32'h4,dw(32'h4));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].rr, tbl[i].sv, tbl[i].sd, tbl[i].ir);
      chk_out($sformatf("vec%0d", i), tbl[i].e_rv, tbl[i].e_addr, tbl[i].e_iv, tbl[i].e_pc, tbl[i].e_data);
    end

    // Redirect with two requests outstanding at latency 3: both words dropped
    cyc(0,0,0, 0,0,0, 1);
    cyc(1,0,0, 1,0,0, 1);                        chk_out("rd c0", 1, 32'h0, 0, 0, 0);
    cyc(1,0,0, 1,0,0, 1);                        chk_out("rd c1", 1, 32'h4, 0, 0, 0);
    cyc(1,1,32'h100, 0,0,0, 1);                  chk_out("rd c2", 0, 32'h8, 0, 0, 0);
    cyc(1,0,0, 1,1,dw(32'h0), 1);                chk_out("rd c3", 1, 32'h100, 0, 0, 0);
    cyc(1,0,0, 0,1,dw(32'h4), 1);                chk_out("rd c4", 1, 32'h104, 0, 0, 0);
    cyc(1,0,0, 0,0,0, 1);                        chk_out("rd c5", 1, 32'h104, 0, 0, 0);
    cyc(1,0,0, 0,1,dw(32'h100), 1);              chk_out("rd c6", 1, 32'h104, 0, 0, 0);
    cyc(1,0,0, 0,0,0, 1);                        chk_out("rd c7", 1, 32'h104, 1, 32'h100, dw(32'h100));

    // Response coincides with redirect, one more still owed: no stale word to decode
    cyc(0,0,0, 0,0,0, 1);
    cyc(1,0,0, 1,0,0, 1);                        chk_out("rr c0", 1, 32'h0, 0, 0, 0);
    cyc(1,0,0, 1,0,0, 1);                        chk_out("rr c1", 1, 32'h4, 0, 0, 0);
    cyc(1,1,32'h200, 0,1,dw(32'h0), 1);          chk_out("rr c2", 0, 32'h8, 0, 0, 0);
    cyc(1,0,0, 1,1,dw(32'h4), 1);                chk_out("rr c3", 1, 32'h200, 0, 0, 0);
    cyc(1,0,0, 0,0,0, 1);                        chk_out("rr c4", 1, 32'h204, 0, 0, 0);
    cyc(1,0,0, 0,1,dw(32'h200), 1);              chk_out("rr c5", 1, 32'h204, 0, 0, 0);
    cyc(1,0,0, 0,0,0, 1);                        chk_out("rr c6", 1, 32'h204, 1, 32'h200, dw(32'h200));

    // PC wraps from the top word to zero
    cyc(0,0,0, 0,0,0, 1);
    cyc(1,1,32'hFFFF_FFFC, 1,0,0, 1);            chk_out("wr c0", 0, 32'h0, 0, 0, 0);
    cyc(1,0,0, 1,0,0, 1);                        chk_out("wr c1", 1, 32'hFFFF_FFFC, 0, 0, 0);
    cyc(1,0,0, 1,0,0, 1);                        chk_out("wr c2", 1, 32'h0, 0, 0, 0);
    cyc(1,0,0, 1,0,0, 1);                        chk_out("wr c3", 1, 32'h4, 0, 0, 0);

    // Async reset mid-stream with a full queue
    cyc(0,0,0, 0,0,0, 0);
    cyc(1,0,0, 1,0,0, 0);
    cyc(1,0,0, 1,1,dw(32'h0), 0);
    cyc(1,0,0, 1,1,dw(32'h4), 0);
    cyc(1,0,0, 1,1,dw(32'h8), 0);
    cyc(1,0,0, 1,1,dw(32'hC), 0);
    cyc(1,0,0, 1,0,0, 0);                        chk_out("rs full", 0, 32'h10, 1, 32'h0, dw(32'h0));
    #2;
    reset_n = 1'b0;
    #1;
    chk("rs async req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rs async instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rs async req_addr", imem_req_addr, 32'h0);
    cyc(0,0,0, 1,0,0, 0);                        chk_out("rs held", 0, 32'h0, 0, 0, 0);
    cyc(1,0,0, 1,0,0, 0);                        chk_out("rs rel", 1, 32'h0, 0, 0, 0);
    cyc(1,0,0, 1,0,0, 0);                        chk_out("rs next", 1, 32'h4, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
